// File: rtl/chacha20_pkg.sv
// ChaCha20 shared constants, FSM encoding and block-state helpers.
// Vectors hold 32-bit word i at bits [32i+31:32i].
package chacha20_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam int NUM_DOUBLE_ROUNDS = 10;
  localparam int BLOCK_BYTES       = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_ADD,
    ST_STREAM
  } state_e;

  // Words 0..3 sigma, 4..11 key, 12 counter, 13..15 nonce.
  function automatic logic [511:0] initial_state(
    input logic [255:0] key,
    input logic [95:0]  nonce,
    input logic [31:0]  counter
  );
    return {nonce, counter, key,
            SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  endfunction

  // Packed as {d, c, b, a}.
  function automatic logic [127:0] quarter_round(
    input logic [127:0] abcd
  );
    logic [31:0] a, b, c, d;
    {d, c, b, a} = abcd;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

endpackage

// File: rtl/chacha20_column_and_diagonal_round.sv
// One ChaCha20 double round: four column quarter rounds
// followed by four diagonal quarter rounds, purely combinational.
module chacha20_column_and_diagonal_round
  import chacha20_pkg::*;
(
  input  logic [511:0] state_i,
  output logic [511:0] state_o
);

  logic [15:0][31:0] w;
  logic [15:0][31:0] c;
  logic [15:0][31:0] d;

  assign w = state_i;

  // Column pass then diagonal pass.
  always_comb begin
    c = w;
    {c[12], c[8], c[4], c[0]} =
      quarter_round({w[12], w[8], w[4], w[0]});
    {c[13], c[9], c[5], c[1]} =
      quarter_round({w[13], w[9], w[5], w[1]});
    {c[14], c[10], c[6], c[2]} =
      quarter_round({w[14], w[10], w[6], w[2]});
    {c[15], c[11], c[7], c[3]} =
      quarter_round({w[15], w[11], w[7], w[3]});
    d = c;
    {d[15], d[10], d[5], d[0]} =
      quarter_round({c[15], c[10], c[5], c[0]});
    {d[12], d[11], d[6], d[1]} =
      quarter_round({c[12], c[11], c[6], c[1]});
    {d[13], d[8], d[7], d[2]} =
      quarter_round({c[13], c[8], c[7], c[2]});
    {d[14], d[9], d[4], d[3]} =
      quarter_round({c[14], c[9], c[4], c[3]});
  end

  assign state_o = d;

endmodule

// File: rtl/chacha20_serial_decoder.sv
// Streaming ChaCha20 decryptor: iterative block function feeding
// a byte-wide XOR with valid/ready on both sides.
module chacha20_serial_decoder
  import chacha20_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         busy
);

  state_e       state_q;
  logic [511:0] work_q;
  logic [511:0] ks_q;
  logic [255:0] key_q;
  logic [95:0]  nonce_q;
  logic [31:0]  blk_q;
  logic [3:0]   round_cnt_q;
  logic [5:0]   byte_idx_q;
  logic         out_valid_q;
  logic [7:0]   out_data_q;

  logic [511:0] round_d;
  logic [511:0] ks_d;
  logic [511:0] init_cur;
  logic [511:0] init_nxt;
  logic [31:0]  blk_d;
  logic [7:0]   ks_byte;
  logic         accept;

  chacha20_column_and_diagonal_round u_round (
    .state_i (work_q),
    .state_o (round_d)
  );

  assign blk_d    = blk_q + 32'd1;
  assign init_cur = initial_state(key_q, nonce_q, blk_q);
  assign init_nxt = initial_state(key_q, nonce_q, blk_d);

  // Feed-forward add, word-wise with no carry between words.
  always_comb begin
    ks_d = '0;
    for (int i = 0; i < 16; i++) begin
      ks_d[32*i +: 32] = work_q[32*i +: 32]
                       + init_cur[32*i +: 32];
    end
  end

  assign ks_byte = ks_q[{byte_idx_q, 3'b000} +: 8];

  // A pending start blocks the input so no byte straddles messages.
  assign in_ready = (state_q == ST_STREAM) && !start
                 && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

  // Control FSM, keystream datapath and output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      ks_q        <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      blk_q       <= '0;
      round_cnt_q <= '0;
      byte_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data ^ ks_byte;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (start) begin
        key_q       <= key;
        nonce_q     <= nonce;
        blk_q       <= counter;
        work_q      <= initial_state(key, nonce, counter);
        round_cnt_q <= '0;
        byte_idx_q  <= '0;
        state_q     <= ST_ROUND;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
          end
          ST_ROUND: begin
            work_q      <= round_d;
            round_cnt_q <= round_cnt_q + 4'd1;
            if (round_cnt_q == 4'(NUM_DOUBLE_ROUNDS - 1))
              state_q <= ST_ADD;
          end
          ST_ADD: begin
            ks_q       <= ks_d;
            byte_idx_q <= '0;
            state_q    <= ST_STREAM;
          end
          ST_STREAM: begin
            if (accept) begin
              byte_idx_q <= byte_idx_q + 6'd1;
              if (byte_idx_q == 6'(BLOCK_BYTES - 1)) begin
                blk_q       <= blk_d;
                work_q      <= init_nxt;
                round_cnt_q <= '0;
                state_q     <= ST_ROUND;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha20_serial_decoder.sv
// Scoreboard bench for chacha20_serial_decoder against an
// independent loop-based ChaCha20 block model.
module tb_chacha20_serial_decoder;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         busy;

  chacha20_serial_decoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .key       (key),
    .nonce     (nonce),
    .counter   (counter),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  string msg = {"Ladies and Gentlemen of the class of '99: ",
                "If I could offer you only one tip for the ",
                "future, sunscreen would be it."};

  int         n_run = 0;
  int         n_fail = 0;
  logic [7:0] sb [$];
  logic [7:0] rx [$];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  bit         hold = 0;
  logic [7:0] held = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v,
                                       input int sh);
    return (v << sh) | (v >> (32 - sh));
  endfunction

  function automatic logic [511:0] ref_block(
    input logic [255:0] k,
    input logic [95:0]  n,
    input logic [31:0]  c
  );
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    int a, b, cc, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    for (int i = 0; i < 16; i++) x[i] = s[i];
    for (int rn = 0; rn < 20; rn++) begin
      for (int q = 0; q < 4; q++) begin
        a = q;
        if (rn % 2 == 0) begin
          b = q + 4; cc = q + 8; d = q + 12;
        end else begin
          b = 4 + (q + 1) % 4;
          cc = 8 + (q + 2) % 4;
          d = 12 + (q + 3) % 4;
        end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // mode 0: zero ciphertext, 1: RFC text, 2: random text
  task automatic prep(input logic [255:0] k, input logic [95:0] n,
                      input logic [31:0] c, input int len,
                      input int mode);
    logic [511:0] blk;
    logic [7:0]   ks, p;
    blk = '0;
    key = k; nonce = n; counter = c;
    for (int i = 0; i < len; i++) begin
      if (i % 64 == 0) blk = ref_block(k, n, c + 32'(i / 64));
      ks = blk[8*(i%64) +: 8];
      if (mode == 0) begin
        ct_mem[i] = 8'h00; pt_mem[i] = ks;
      end else begin
        p = (mode == 1) ? msg[i] : 8'($urandom);
        ct_mem[i] = p ^ ks; pt_mem[i] = p;
      end
    end
  endtask

  // One cycle: drive after negedge, observe the coming handshakes.
  task automatic tick(input bit st, input bit iv,
                      input logic [7:0] d, input logic [7:0] e,
                      input bit ordy, output bit acc, output bit rdy);
    @(negedge clock);
    if (hold) chk("stall_hold", 32'(out_data), 32'(held));
    start = st; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    rdy  = in_ready;
    acc  = iv && in_ready;
    hold = out_valid && !ordy;
    held = out_data;
    if (out_valid && ordy) begin
      rx.push_back(out_data);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("data", 32'(out_data),
                              32'(sb.pop_front()));
    end
    if (acc) sb.push_back(e);
  endtask

  task automatic pulse_start(input bit iv, input bit ordy);
    bit acc, rdy;
    tick(1'b1, iv, 8'h5a, 8'h00, ordy, acc, rdy);
    if (iv) chk("start_blocks_in", 32'({rdy, acc}), 32'd0);
  endtask

  task automatic wait_ready(input bit chklat);
    int lat = 0;
    bit acc, rdy;
    rdy = 1'b0;
    while (!rdy && lat < 40) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, rdy);
      lat++;
    end
    if (chklat) chk("first_ready_lat", 32'(lat), 32'd12);
    else chk("ready_seen", 32'(rdy), 32'd1);
  endtask

  task automatic stream(input int n, input bit rnd,
                        input bit drain, input bit gapchk);
    int sent = 0;
    int cyc = 0;
    int gap = 0;
    bit ingap = 0;
    bit acc, rdy, iv, ordy;
    while ((sent < n || (drain && sb.size() != 0)) && cyc < 4000) begin
      iv   = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      ordy = !rnd || $urandom_range(0, 2) != 0;
      tick(1'b0, iv, ct_mem[sent], pt_mem[sent], ordy, acc, rdy);
      if (ingap) begin
        if (rdy) begin
          chk("block_gap", 32'(gap), 32'd11);
          ingap = 0;
        end else gap++;
      end
      if (acc) begin
        sent++;
        if (gapchk && sent % 64 == 0 && sent < n) begin
          ingap = 1; gap = 0;
        end
      end
      cyc++;
    end
    chk("stream_done", 32'(cyc < 4000), 32'd1);
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [255:0] k_rfc;
  logic [95:0]  n232 = 96'h00000000_4a000000_09000000;
  logic [95:0]  n242 = 96'h00000000_4a000000_00000000;

  task automatic check_232(input string tag);
    chk({tag, "_b0"}, 32'(rx[0]), 32'h10);
    chk({tag, "_b1"}, 32'(rx[1]), 32'hf1);
    chk({tag, "_b7"}, 32'(rx[7]), 32'h15);
    chk({tag, "_b63"}, 32'(rx[63]), 32'h4e);
  endtask

  initial begin
    bit acc, rdy;
    for (int b = 0; b < 32; b++) k_rfc[8*b +: 8] = 8'(b);

    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    prep(k_rfc, n232, 32'd1, 64, 0);
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b1);
    rx.delete();
    stream(64, 1'b0, 1'b1, 1'b0);
    check_232("rfc232");

    prep(k_rfc, n242, 32'd1, 114, 1);
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b1);
    rx.delete();
    stream(114, 1'b0, 1'b1, 1'b1);
    chk("rfc242_b0", 32'(rx[0]), 32'h4c);
    chk("rfc242_len", 32'(rx.size()), 32'd114);

    prep(k_rfc, n242, 32'd1, 114, 1);
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b0);
    rx.delete();
    stream(114, 1'b1, 1'b1, 1'b0);
    chk("bp_len", 32'(rx.size()), 32'd114);

    prep(rnd256(), {$urandom(), $urandom(), $urandom()},
         32'hFFFFFFFF, 128, 0);
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b1);
    stream(128, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc, rdy);
    chk("wrap_drained", 32'(out_valid), 32'd0);

    prep(rnd256(), {$urandom(), $urandom(), $urandom()},
         $urandom(), 64, 2);
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b1);
    stream(20, 1'b0, 1'b0, 1'b0);
    prep(rnd256(), {$urandom(), $urandom(), $urandom()},
         $urandom(), 64, 2);
    pulse_start(1'b0, 1'b0);
    wait_ready(1'b1);
    stream(30, 1'b0, 1'b0, 1'b0);
    prep(k_rfc, n232, 32'd1, 64, 0);
    pulse_start(1'b1, 1'b1);
    wait_ready(1'b1);
    rx.delete();
    stream(64, 1'b0, 1'b1, 1'b0);
    check_232("restart");

    prep(rnd256(), {$urandom(), $urandom(), $urandom()},
         $urandom(), 64, 2);
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b0);
    stream(10, 1'b0, 1'b0, 1'b0);
    prep(k_rfc, n232, 32'd1, 64, 0);
    pulse_start(1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, acc, rdy);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_pending", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    sb.delete();
    hold = 0;
    @(negedge clock);
    reset_n = 1'b1;
    pulse_start(1'b0, 1'b1);
    wait_ready(1'b1);
    rx.delete();
    stream(64, 1'b0, 1'b1, 1'b0);
    check_232("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
